bb_uart_cmd_rx: RTL and testbench

- Receive end of the inter-bus UART bridge link: deserialises 8N1 bytes from the peer bridge's TX line and assembles them into bus command frames.
- Presents each complete frame as one transaction on a valid/ready interface to the local bus-bridge master.
- Sits between the UART pin (uart_rx / m_u_rx net) and the bridge master FSM.
- Flags line, protocol, overrun and timeout errors as single-cycle pulses.

---
 rtl/bb_uart_cmd_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_bb_uart_cmd_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : bb_uart_cmd_rx
//  Description : Receive side of the inter-bus UART bridge link. Deserialises
//                8N1 bytes from the peer TX line, assembles them into
//                read/write command frames and presents each frame as one
//                valid/ready transaction. Error conditions pulse for 1 cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bb_uart_cmd_rx #(
    parameter int UART_CLOCKS_PER_PULSE = 5208,
    parameter int ADDR_WIDTH            = 16,
    parameter int TIMEOUT_BITS          = 40
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  u_rx,
    output logic                  txn_valid,
    input  logic                  txn_ready,
    output logic                  txn_write,
    output logic [ADDR_WIDTH-1:0] txn_addr,
    output logic [7:0]            txn_wdata,
    output logic                  err_framing,
    output logic                  err_cmd,
    output logic                  err_overrun,
    output logic                  err_timeout,
    output logic                  busy
);

    localparam int c_HALF      = UART_CLOCKS_PER_PULSE / 2;
    localparam int c_CNT_W     = $clog2(UART_CLOCKS_PER_PULSE);
    localparam int c_TMO_LIMIT = TIMEOUT_BITS * UART_CLOCKS_PER_PULSE;
    localparam int c_TMO_W     = $clog2(c_TMO_LIMIT + 1);

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(UART_CLOCKS_PER_PULSE - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(c_TMO_LIMIT - 1);

    localparam logic [7:0] c_CMD_WR = 8'hA5;
    localparam logic [7:0] c_CMD_RD = 8'h5A;

    // Bit-level receiver states
    localparam logic [1:0] c_BIT_IDLE  = 2'd0;
    localparam logic [1:0] c_BIT_START = 2'd1;
    localparam logic [1:0] c_BIT_DATA  = 2'd2;
    localparam logic [1:0] c_BIT_STOP  = 2'd3;

    // Frame assembler states
    localparam logic [1:0] c_F_CMD  = 2'd0;
    localparam logic [1:0] c_F_AH   = 2'd1;
    localparam logic [1:0] c_F_AL   = 2'd2;
    localparam logic [1:0] c_F_DATA = 2'd3;

    logic                  r_rx_meta;
    logic                  r_rx_sync;
    logic [1:0]            r_bit_state;
    logic [1:0]            w_bit_next;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_byte_valid;
    logic                  r_err_framing;
    logic                  w_tick;
    logic                  w_data_smp;
    logic                  w_stop_ok;
    logic                  w_stop_bad;

    logic [1:0]            r_frm_state;
    logic [1:0]            w_frm_next;
    logic                  r_is_write;
    logic [7:0]            r_addr_hi;
    logic [7:0]            r_addr_lo;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic                  w_is_wr;
    logic                  w_is_rd;
    logic                  w_tmo_run;
    logic                  w_timeout;
    logic                  w_bad_cmd;
    logic                  w_complete;
    logic                  w_load;
    logic                  w_overrun;
    logic [15:0]           w_addr16;

    logic                  r_txn_valid;
    logic                  r_txn_write;
    logic [ADDR_WIDTH-1:0] r_txn_addr;
    logic [7:0]            r_txn_wdata;
    logic                  r_err_cmd;
    logic                  r_err_overrun;
    logic                  r_err_timeout;

    // Two-flop synchroniser; presets to idle-high so reset release is quiet
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= u_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Bit FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_bit_state <= c_BIT_IDLE;
        else       r_bit_state <= w_bit_next;
    end

    // Bit FSM next state; STOP returns to IDLE at mid-bit so back-to-back bytes work
    always_comb begin
        w_bit_next = r_bit_state;
        case (r_bit_state)
            c_BIT_IDLE:  if (!r_rx_sync) w_bit_next = c_BIT_START;
            c_BIT_START: if (w_tick) w_bit_next = r_rx_sync ? c_BIT_IDLE : c_BIT_DATA;
            c_BIT_DATA:  if (w_tick && (r_bit_idx == 3'd7)) w_bit_next = c_BIT_STOP;
            c_BIT_STOP:  if (w_tick) w_bit_next = c_BIT_IDLE;
            default:     w_bit_next = c_BIT_IDLE;
        endcase
    end

    // Bit FSM outputs: sample strobes at half a bit (start) or a full bit (data/stop)
    always_comb begin
        w_tick = 1'b0;
        case (r_bit_state)
            c_BIT_START:           w_tick = (r_bit_cnt == c_HALF_LAST);
            c_BIT_DATA, c_BIT_STOP: w_tick = (r_bit_cnt == c_BIT_LAST);
            default:               w_tick = 1'b0;
        endcase
        w_data_smp = (r_bit_state == c_BIT_DATA) && w_tick;
        w_stop_ok  = (r_bit_state == c_BIT_STOP) && w_tick && r_rx_sync;
        w_stop_bad = (r_bit_state == c_BIT_STOP) && w_tick && !r_rx_sync;
    end

    // Bit timing counter, LSB-first shift register and byte/framing strobes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bit_cnt     <= '0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_byte_valid  <= 1'b0;
            r_err_framing <= 1'b0;
        end else begin
            r_byte_valid  <= w_stop_ok;
            r_err_framing <= w_stop_bad;
            if ((r_bit_state == c_BIT_IDLE) || w_tick) r_bit_cnt <= '0;
            else                                       r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_state == c_BIT_IDLE) r_bit_idx <= 3'd0;
            else if (w_data_smp)           r_bit_idx <= r_bit_idx + 3'd1;
            if (w_data_smp) r_shift <= {r_rx_sync, r_shift[7:1]};
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_frm_state <= c_F_CMD;
        else       r_frm_state <= w_frm_next;
    end

    // Frame FSM next state; framing errors and timeouts abandon the frame
    always_comb begin
        w_frm_next = r_frm_state;
        if (w_stop_bad || w_timeout) begin
            w_frm_next = c_F_CMD;
        end else if (r_byte_valid) begin
            case (r_frm_state)
                c_F_CMD:  if (w_is_wr || w_is_rd) w_frm_next = c_F_AH;
                c_F_AH:   w_frm_next = c_F_AL;
                c_F_AL:   w_frm_next = r_is_write ? c_F_DATA : c_F_CMD;
                c_F_DATA: w_frm_next = c_F_CMD;
                default:  w_frm_next = c_F_CMD;
            endcase
        end
    end

    // Frame FSM outputs: command decode, completion, overrun and timeout detection
    always_comb begin
        w_is_wr    = (r_shift == c_CMD_WR);
        w_is_rd    = (r_shift == c_CMD_RD);
        w_bad_cmd  = r_byte_valid && (r_frm_state == c_F_CMD) && !w_is_wr && !w_is_rd;
        w_complete = r_byte_valid &&
                     (((r_frm_state == c_F_AL) && !r_is_write) || (r_frm_state == c_F_DATA));
        w_load     = w_complete && (!r_txn_valid || txn_ready);
        w_overrun  = w_complete && !w_load;
        // a byte_valid on the counter's last cycle wins, the frame is still alive
        w_tmo_run  = (r_frm_state != c_F_CMD) && (r_bit_state == c_BIT_IDLE);
        w_timeout  = w_tmo_run && !r_byte_valid && (r_tmo_cnt == c_TMO_LAST);
        w_addr16   = (r_frm_state == c_F_AL) ? {r_addr_hi, r_shift} : {r_addr_hi, r_addr_lo};
    end

    // Frame fields, inter-byte timeout counter, output holding register and error pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_is_write    <= 1'b0;
            r_addr_hi     <= 8'h00;
            r_addr_lo     <= 8'h00;
            r_tmo_cnt     <= '0;
            r_txn_valid   <= 1'b0;
            r_txn_write   <= 1'b0;
            r_txn_addr    <= '0;
            r_txn_wdata   <= 8'h00;
            r_err_cmd     <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_cmd     <= w_bad_cmd;
            r_err_overrun <= w_overrun;
            r_err_timeout <= w_timeout;
            if (r_byte_valid && (r_frm_state == c_F_CMD) && (w_is_wr || w_is_rd))
                r_is_write <= w_is_wr;
            if (r_byte_valid && (r_frm_state == c_F_AH)) r_addr_hi <= r_shift;
            if (r_byte_valid && (r_frm_state == c_F_AL)) r_addr_lo <= r_shift;
            // frozen while a byte is in flight so it cannot collide with a framing error
            if (r_byte_valid || (r_frm_state == c_F_CMD) || w_timeout) r_tmo_cnt <= '0;
            else if (w_tmo_run)                                      r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_load) begin
                r_txn_valid <= 1'b1;
                r_txn_write <= r_is_write;
                r_txn_addr  <= w_addr16[ADDR_WIDTH-1:0];
                r_txn_wdata <= (r_frm_state == c_F_DATA) ? r_shift : 8'h00;
            end else if (txn_ready) begin
                r_txn_valid <= 1'b0;
            end
        end
    end

    assign txn_valid   = r_txn_valid;
    assign txn_write   = r_txn_write;
    assign txn_addr    = r_txn_addr;
    assign txn_wdata   = r_txn_wdata;
    assign err_framing = r_err_framing;
    assign err_cmd     = r_err_cmd;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;
    assign busy        = (r_frm_state != c_F_CMD) || (r_bit_state != c_BIT_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bb_uart_cmd_rx
//  Description : Self-checking bench for bb_uart_cmd_rx. A byte-level frame
//                model predicts transactions and error pulses; a negedge
//                monitor checks the DUT against it every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bb_uart_cmd_rx;

    localparam int CPP = 16;
    localparam int TMO = 4;
    localparam int AW  = 16;

    localparam int E_FRAMING = 1;
    localparam int E_CMD     = 2;
    localparam int E_OVERRUN = 3;
    localparam int E_TIMEOUT = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          u_rx;
    logic          txn_valid;
    logic          txn_ready;
    logic          txn_write;
    logic [AW-1:0] txn_addr;
    logic [7:0]    txn_wdata;
    logic          err_framing;
    logic          err_cmd;
    logic          err_overrun;
    logic          err_timeout;
    logic          busy;

    always #5 clk = ~clk;

    bb_uart_cmd_rx #(
        .UART_CLOCKS_PER_PULSE(CPP),
        .ADDR_WIDTH           (AW),
        .TIMEOUT_BITS         (TMO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .u_rx       (u_rx),
        .txn_valid  (txn_valid),
        .txn_ready  (txn_ready),
        .txn_write  (txn_write),
        .txn_addr   (txn_addr),
        .txn_wdata  (txn_wdata),
        .err_framing(err_framing),
        .err_cmd    (err_cmd),
        .err_overrun(err_overrun),
        .err_timeout(err_timeout),
        .busy       (busy)
    );

    typedef struct packed {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } txn_t;

    txn_t       exp_txn[$];
    int         exp_err[$];
    logic [7:0] fbytes[$];
    bit         m_held = 1'b0;
    int         total = 0;
    int         bad = 0;
    txn_t       last_acc = '0;
    int         acc_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s actual=%0h expected=none at %0t", name, act, $time);
    endtask

    // ---------------- byte-level frame model ----------------
    task automatic model_byte(input logic [7:0] b, input bit bad_stop);
        txn_t t;
        int   need;
        if (bad_stop) begin
            exp_err.push_back(E_FRAMING);
            fbytes.delete();
        end else if (fbytes.size() == 0) begin
            if (b == 8'hA5 || b == 8'h5A) fbytes.push_back(b);
            else                          exp_err.push_back(E_CMD);
        end else begin
            fbytes.push_back(b);
            need = (fbytes[0] == 8'hA5) ? 4 : 3;
            if (fbytes.size() == need) begin
                t.w = (fbytes[0] == 8'hA5);
                t.a = {fbytes[1], fbytes[2]};
                if (t.w) t.d = fbytes[3];
                else     t.d = 8'h00;
                if (!m_held || txn_ready) begin
                    exp_txn.push_back(t);
                    m_held = !txn_ready;
                end else begin
                    exp_err.push_back(E_OVERRUN);
                end
                fbytes.delete();
            end
        end
    endtask

    task automatic model_timeout();
        if (fbytes.size() != 0) begin
            exp_err.push_back(E_TIMEOUT);
            fbytes.delete();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_bits(input int n);
        if (n >= TMO + 1) model_timeout();
        u_rx = 1'b1;
        repeat (n * CPP) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
        model_byte(b, bad_stop);
        u_rx = 1'b0;
        repeat (CPP) tick();
        for (int i = 0; i < 8; i++) begin
            u_rx = b[i];
            repeat (CPP) tick();
        end
        u_rx = !bad_stop;
        repeat (CPP) tick();
        u_rx = 1'b1;
        if (bad_stop) idle_bits(2);
    endtask

    task automatic set_ready(input logic v);
        txn_ready = v;
        if (v) m_held = 1'b0;
    endtask

    task automatic drain(input string tag);
        check({tag, "_drain_err"}, exp_err.size(), 0);
        check({tag, "_drain_txn"}, exp_txn.size(), 0);
    endtask

    // ---------------- per-cycle monitor ----------------
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    txn_t       p_txn = '0;
    logic [3:0] p_errs = 4'h0;

    always @(negedge clk) begin
        txn_t       cur;
        logic [3:0] errs;
        cur  = {txn_write, txn_addr, txn_wdata};
        errs = {err_framing, err_cmd, err_overrun, err_timeout};
        if (!rstn) begin
            p_valid = 1'b0;
            p_errs  = 4'h0;
        end else begin
            if (p_valid && !p_ready) begin
                check("hold_valid", txn_valid, 1'b1);
                check("hold_fields", cur, p_txn);
            end
            if (txn_valid && txn_ready) begin
                if (exp_txn.size() == 0) fail_unexpected("txn_unexpected", cur);
                else begin
                    check("txn", cur, exp_txn.pop_front());
                    last_acc = cur;
                    acc_count++;
                end
            end
            if ((errs & p_errs) != 4'h0) fail_unexpected("pulse_width", errs);
            for (int k = 0; k < 4; k++) begin
                if (errs[3-k]) begin
                    if (exp_err.size() == 0) fail_unexpected("err_unexpected", k + 1);
                    else                     check("err_kind", k + 1, exp_err.pop_front());
                end
            end
            p_valid = txn_valid;
            p_ready = txn_ready;
            p_txn   = cur;
            p_errs  = errs;
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        rstn = 1'b0;
        u_rx = 1'b1;
        txn_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_outs", {txn_valid, txn_write, txn_addr, txn_wdata,
                             err_framing, err_cmd, err_overrun, err_timeout, busy}, 0);
        tick();
        rstn = 1'b1;
        idle_bits(1);

        // 1: clean write frame
        set_ready(1'b1);
        send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h5C);
        idle_bits(2);
        check("t1_txn", last_acc, {1'b1, 16'h1234, 8'h5C});
        drain("t1");

        // 2: held read, then overrun by a write frame
        set_ready(1'b0);
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h7F);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h80); send_byte(8'h01);
        idle_bits(2);
        @(negedge clk);
        check("t2_held", {txn_valid, txn_write, txn_addr, txn_wdata}, {1'b1, 1'b0, 16'h007F, 8'h00});
        tick();
        set_ready(1'b1);
        idle_bits(1);
        @(negedge clk);
        check("t2_valid_clear", txn_valid, 1'b0);
        check("t2_acc", last_acc, {1'b0, 16'h007F, 8'h00});
        check("t2_count", acc_count, 2);
        drain("t2");

        // 3: unknown command byte, then a read
        send_byte(8'h33);
        send_byte(8'h5A); send_byte(8'h01); send_byte(8'h02);
        idle_bits(2);
        check("t3_txn", last_acc, {1'b0, 16'h0102, 8'h00});
        drain("t3");

        // 4: framing error on the address-high byte, then a clean write
        send_byte(8'hA5); send_byte(8'h12, 1'b1); send_byte(8'h34); send_byte(8'h5C);
        idle_bits(2);
        check("t4_no_txn", acc_count, 3);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'hFF);
        idle_bits(2);
        check("t4_txn", last_acc, {1'b1, 16'h0001, 8'hFF});
        drain("t4");

        // 5: inter-byte timeout abandons a partial frame
        send_byte(8'hA5); send_byte(8'h12);
        idle_bits(5);
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h10);
        idle_bits(2);
        check("t5_txn", last_acc, {1'b0, 16'h0010, 8'h00});
        drain("t5");

        // 6: short glitch, then reset in the middle of the second byte
        u_rx = 1'b0;
        repeat (4) tick();
        idle_bits(3);
        check("t6_glitch", acc_count, 5);
        send_byte(8'hA5);
        u_rx = 1'b0;
        repeat (40) tick();
        drain("t6a");
        rstn = 1'b0;
        u_rx = 1'b1;
        fbytes.delete();
        m_held = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("t6_reset_outs", {txn_valid, txn_write, txn_addr, txn_wdata,
                                err_framing, err_cmd, err_overrun, err_timeout, busy}, 0);
        tick();
        rstn = 1'b1;
        idle_bits(1);
        send_byte(8'hA5); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h77);
        idle_bits(2);
        check("t6_txn", last_acc, {1'b1, 16'hABCD, 8'h77});
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
